// File: rtl/tetris_board.sv
// Tetris playfield: occupancy store, probe-move collision check, and the
// placement / line-clear sequencer with a registered display read port.
module tetris_board #(
  parameter int BOARD_WIDTH  = 10,
  parameter int BOARD_HEIGHT = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             piece_x,
  input  logic [4:0]             piece_y,
  input  logic [2:0]             piece_type,
  input  logic [1:0]             piece_rot,
  input  logic [2:0]             probe,
  input  logic                   place_piece,
  input  logic                   board_clear,
  input  logic [4:0]             rd_row,
  output logic                   collision,
  output logic                   busy,
  output logic                   clear_done,
  output logic [3:0]             lines_cleared,
  output logic [BOARD_WIDTH-1:0] rd_data
);

  typedef enum logic [1:0] {IDLE, PLACE, SCAN, SHIFT} state_e;

  localparam logic signed [6:0] WidthS  = 7'(BOARD_WIDTH);
  localparam logic signed [6:0] HeightS = 7'(BOARD_HEIGHT);
  localparam logic [4:0]        LastRow = 5'(BOARD_HEIGHT - 1);
  localparam logic [4:0]        NumRows = 5'(BOARD_HEIGHT);

  // Cell offsets of a rotated piece; cell i sits in bits [4i+3:4i] as {col,row}.
  function automatic logic [15:0] shapeCells(input logic [2:0] ptype,
                                             input logic [1:0] rot);
    logic [1:0]  c [4];
    logic [1:0]  r [4];
    logic [1:0]  nm1;
    logic [1:0]  t;
    logic [15:0] cellBits;
    nm1 = 2'd2;
    case (ptype)
      3'd0: begin
        c = '{2'd0, 2'd1, 2'd2, 2'd3}; r = '{2'd1, 2'd1, 2'd1, 2'd1}; nm1 = 2'd3;
      end
      3'd1: begin
        c = '{2'd0, 2'd0, 2'd1, 2'd2}; r = '{2'd0, 2'd1, 2'd1, 2'd1};
      end
      3'd2: begin
        c = '{2'd2, 2'd0, 2'd1, 2'd2}; r = '{2'd0, 2'd1, 2'd1, 2'd1};
      end
      3'd3: begin
        c = '{2'd0, 2'd1, 2'd0, 2'd1}; r = '{2'd0, 2'd0, 2'd1, 2'd1}; nm1 = 2'd1;
      end
      3'd4: begin
        c = '{2'd1, 2'd2, 2'd0, 2'd1}; r = '{2'd0, 2'd0, 2'd1, 2'd1};
      end
      3'd5: begin
        c = '{2'd1, 2'd0, 2'd1, 2'd2}; r = '{2'd0, 2'd1, 2'd1, 2'd1};
      end
      default: begin
        c = '{2'd0, 2'd1, 2'd1, 2'd2}; r = '{2'd0, 2'd0, 2'd1, 2'd1};
      end
    endcase
    for (int s = 0; s < 3; s++) begin
      if (s < int'(rot)) begin
        for (int i = 0; i < 4; i++) begin
          t    = c[i];
          c[i] = nm1 - r[i];
          r[i] = t;
        end
      end
    end
    cellBits = '0;
    for (int i = 0; i < 4; i++) begin
      cellBits[4*i +: 4] = {c[i], r[i]};
    end
    return cellBits;
  endfunction

  state_e                 state_q, state_d;
  logic [BOARD_WIDTH-1:0] board_q [BOARD_HEIGHT];
  logic [BOARD_WIDTH-1:0] board_d [BOARD_HEIGHT];
  logic [4:0]             idx_q, idx_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [3:0]             lines_q, lines_d;
  logic                   clearDone_q, clearDone_d;
  logic                   collision_q, collision_d;
  logic [BOARD_WIDTH-1:0] rdData_q, rdData_d;
  logic [3:0]             pieceX_q, pieceX_d;
  logic [4:0]             pieceY_q, pieceY_d;
  logic [2:0]             pieceType_q, pieceType_d;
  logic [1:0]             pieceRot_q, pieceRot_d;

  logic signed [6:0] probeX, probeY, probeCol, probeRow;
  logic [1:0]        probeRot;
  logic [15:0]       probeCells;

  // Collision of the probed candidate against the current board contents.
  always_comb begin
    probeX      = $signed({3'b000, piece_x});
    probeY      = $signed({2'b00, piece_y});
    probeRot    = piece_rot;
    probeCol    = '0;
    probeRow    = '0;
    collision_d = 1'b0;
    case (probe)
      3'd0:    probeY   = probeY + 7'sd1;
      3'd1:    probeX   = probeX - 7'sd1;
      3'd2:    probeX   = probeX + 7'sd1;
      3'd3:    probeRot = piece_rot + 2'd1;
      default: ;
    endcase
    probeCells = shapeCells(piece_type, probeRot);
    if (piece_type != 3'd7) begin
      for (int i = 0; i < 4; i++) begin
        probeCol = probeX + $signed({5'b00000, probeCells[4*i+2 +: 2]});
        probeRow = probeY + $signed({5'b00000, probeCells[4*i +: 2]});
        if (probeCol < 0 || probeCol >= WidthS || probeRow < 0 || probeRow >= HeightS) begin
          collision_d = 1'b1;
        end else if (board_q[probeRow[4:0]][probeCol[3:0]]) begin
          collision_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdData_d = '0;
    if (rd_row < NumRows) begin
      rdData_d = board_q[rd_row];
    end
  end

  logic signed [6:0] placeCol, placeRow;
  logic [15:0]       placeCells;

  // Placement and line-clear sequencer; board_clear overrides everything.
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    lines_d     = lines_q;
    clearDone_d = 1'b0;
    pieceX_d    = pieceX_q;
    pieceY_d    = pieceY_q;
    pieceType_d = pieceType_q;
    pieceRot_d  = pieceRot_q;
    placeCol    = '0;
    placeRow    = '0;
    placeCells  = shapeCells(pieceType_q, pieceRot_q);

    case (state_q)
      IDLE: begin
        if (place_piece) begin
          pieceX_d    = piece_x;
          pieceY_d    = piece_y;
          pieceType_d = piece_type;
          pieceRot_d  = piece_rot;
          cnt_d       = '0;
          state_d     = PLACE;
        end
      end
      PLACE: begin
        if (pieceType_q != 3'd7) begin
          for (int i = 0; i < 4; i++) begin
            placeCol = $signed({3'b000, pieceX_q}) + $signed({5'b00000, placeCells[4*i+2 +: 2]});
            placeRow = $signed({2'b00, pieceY_q}) + $signed({5'b00000, placeCells[4*i +: 2]});
            if (placeCol < WidthS && placeRow < HeightS) begin
              board_d[placeRow[4:0]][placeCol[3:0]] = 1'b1;
            end
          end
        end
        idx_d   = LastRow;
        state_d = SCAN;
      end
      SCAN: begin
        if (&board_q[idx_q]) begin
          cnt_d   = cnt_q + 4'd1;
          state_d = SHIFT;
        end else if (idx_q != 5'd0) begin
          idx_d = idx_q - 5'd1;
        end else begin
          lines_d     = cnt_q;
          clearDone_d = 1'b1;
          state_d     = IDLE;
        end
      end
      SHIFT: begin
        for (int k = 1; k < BOARD_HEIGHT; k++) begin
          if (k <= int'(idx_q)) begin
            board_d[k] = board_q[k-1];
          end
        end
        board_d[0] = '0;
        state_d    = SCAN;
      end
      default: state_d = IDLE;
    endcase

    if (board_clear) begin
      for (int k = 0; k < BOARD_HEIGHT; k++) begin
        board_d[k] = '0;
      end
      state_d     = IDLE;
      clearDone_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int k = 0; k < BOARD_HEIGHT; k++) begin
        board_q[k] <= '0;
      end
      idx_q       <= '0;
      cnt_q       <= '0;
      lines_q     <= '0;
      clearDone_q <= 1'b0;
      collision_q <= 1'b0;
      rdData_q    <= '0;
      pieceX_q    <= '0;
      pieceY_q    <= '0;
      pieceType_q <= '0;
      pieceRot_q  <= '0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      lines_q     <= lines_d;
      clearDone_q <= clearDone_d;
      collision_q <= collision_d;
      rdData_q    <= rdData_d;
      pieceX_q    <= pieceX_d;
      pieceY_q    <= pieceY_d;
      pieceType_q <= pieceType_d;
      pieceRot_q  <= pieceRot_d;
    end
  end

  assign collision     = collision_q;
  assign busy          = (state_q != IDLE);
  assign clear_done    = clearDone_q;
  assign lines_cleared = lines_q;
  assign rd_data       = rdData_q;

endmodule

// File: tb/tb_tetris_board.sv
// Directed bench for tetris_board: probe collisions, placements with
// line clears, and abort by board_clear and by reset.
module tb_tetris_board;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] piece_x;
  logic [4:0] piece_y;
  logic [2:0] piece_type;
  logic [1:0] piece_rot;
  logic [2:0] probe;
  logic       place_piece;
  logic       board_clear;
  logic [4:0] rd_row;
  logic       collision;
  logic       busy;
  logic       clear_done;
  logic [3:0] lines_cleared;
  logic [9:0] rd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tetris_board dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .piece_x      (piece_x),
    .piece_y      (piece_y),
    .piece_type   (piece_type),
    .piece_rot    (piece_rot),
    .probe        (probe),
    .place_piece  (place_piece),
    .board_clear  (board_clear),
    .rd_row       (rd_row),
    .collision    (collision),
    .busy         (busy),
    .clear_done   (clear_done),
    .lines_cleared(lines_cleared),
    .rd_data      (rd_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] x, input logic [4:0] y, input logic [2:0] t,
                               input logic [1:0] r, input logic [2:0] p);
    piece_x    = x;
    piece_y    = y;
    piece_type = t;
    piece_rot  = r;
    probe      = p;
  endtask

  task automatic probeCheck(input string tag, input logic [3:0] x, input logic [4:0] y,
                            input logic [2:0] t, input logic [1:0] r, input logic [2:0] p,
                            input logic exp);
    applyStimulus(x, y, t, r, p);
    tick;
    checkOutput(tag, collision, exp);
  endtask

  task automatic readCheck(input string tag, input logic [4:0] row, input logic [9:0] exp);
    rd_row = row;
    tick;
    checkOutput(tag, rd_data, exp);
  endtask

  task automatic placeAndWait(input string tag, input logic [3:0] x, input logic [4:0] y,
                              input logic [2:0] t, input logic [1:0] r,
                              input int expLines, input int expLat);
    int  k;
    bit  seen;
    applyStimulus(x, y, t, r, 3'd4);
    place_piece = 1'b1;
    tick;
    place_piece = 1'b0;
    checkOutput({tag, "_busy"}, busy, 1);
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      tick;
      k++;
      if (clear_done) seen = 1'b1;
    end
    checkOutput({tag, "_latency"}, k, expLat);
    checkOutput({tag, "_lines"}, lines_cleared, expLines);
    checkOutput({tag, "_idle"}, busy, 0);
    tick;
    checkOutput({tag, "_pulse"}, clear_done, 0);
  endtask

  task automatic pulseClear;
    board_clear = 1'b1;
    tick;
    board_clear = 1'b0;
  endtask

  task automatic watchNoDone(input string tag);
    int seenCount;
    seenCount = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (clear_done) seenCount++;
    end
    checkOutput(tag, seenCount, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    place_piece = 1'b0;
    board_clear = 1'b0;
    rd_row      = 5'd0;
    applyStimulus(4'd0, 5'd0, 3'd7, 2'd0, 3'd4);
    tick;
    tick;
    checkOutput("rst_collision", collision, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_clear_done", clear_done, 0);
    checkOutput("rst_lines", lines_cleared, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    tick;

    probeCheck("T_left_wall", 4'd0, 5'd0, 3'd5, 2'd0, 3'd1, 1'b1);
    probeCheck("T_right_ok", 4'd0, 5'd0, 3'd5, 2'd0, 3'd2, 1'b0);
    probeCheck("T_asis_ok", 4'd0, 5'd0, 3'd5, 2'd0, 3'd4, 1'b0);
    probeCheck("I_r1_x8", 4'd8, 5'd0, 3'd0, 2'd1, 3'd4, 1'b1);
    probeCheck("I_r1_x6", 4'd6, 5'd0, 3'd0, 2'd1, 3'd4, 1'b0);
    probeCheck("I_r0_right_wall", 4'd6, 5'd0, 3'd0, 2'd0, 3'd2, 1'b1);
    probeCheck("I_rotate_ok", 4'd0, 5'd0, 3'd0, 2'd0, 3'd3, 1'b0);
    probeCheck("J_rotate_x7", 4'd7, 5'd0, 3'd1, 2'd0, 3'd3, 1'b0);
    probeCheck("J_r1_x8", 4'd8, 5'd0, 3'd1, 2'd1, 3'd7, 1'b1);
    probeCheck("empty_type", 4'd15, 5'd31, 3'd7, 2'd0, 3'd4, 1'b0);
    probeCheck("O_floor_y18", 4'd4, 5'd18, 3'd3, 2'd0, 3'd0, 1'b1);
    probeCheck("O_floor_y17", 4'd4, 5'd17, 3'd3, 2'd0, 3'd0, 1'b0);

    placeAndWait("T_spawn", 4'd0, 5'd0, 3'd5, 2'd0, 0, 21);
    readCheck("T_row0", 5'd0, 10'b0000000010);
    readCheck("T_row1", 5'd1, 10'b0000000111);
    readCheck("row_out_of_range", 5'd25, 10'd0);
    probeCheck("T_overlap", 4'd0, 5'd0, 3'd5, 2'd0, 3'd4, 1'b1);
    pulseClear;
    readCheck("clear_row1", 5'd1, 10'd0);

    placeAndWait("O_x0", 4'd0, 5'd18, 3'd3, 2'd0, 0, 21);
    placeAndWait("O_x2", 4'd2, 5'd18, 3'd3, 2'd0, 0, 21);
    placeAndWait("O_x4", 4'd4, 5'd18, 3'd3, 2'd0, 0, 21);
    placeAndWait("O_x6", 4'd6, 5'd18, 3'd3, 2'd0, 0, 21);
    readCheck("prefill_row19", 5'd19, 10'h0FF);
    probeCheck("O_stack_down", 4'd0, 5'd16, 3'd3, 2'd0, 3'd0, 1'b1);
    placeAndWait("O_x8_double", 4'd8, 5'd18, 3'd3, 2'd0, 2, 25);
    readCheck("double_row18", 5'd18, 10'd0);
    readCheck("double_row19", 5'd19, 10'd0);

    for (int i = 0; i < 4; i++) begin
      placeAndWait("build_lo", 4'(2*i), 5'd18, 3'd3, 2'd0, 0, 21);
      placeAndWait("build_hi", 4'(2*i), 5'd16, 3'd3, 2'd0, 0, 21);
    end
    placeAndWait("build_col8", 4'd6, 5'd16, 3'd0, 2'd1, 0, 21);
    readCheck("build_row16", 5'd16, 10'h1FF);
    readCheck("build_row19", 5'd19, 10'h1FF);
    probeCheck("I_col9_free", 4'd7, 5'd16, 3'd0, 2'd1, 3'd4, 1'b0);
    probeCheck("I_col8_down", 4'd6, 5'd15, 3'd0, 2'd1, 3'd0, 1'b1);
    placeAndWait("tetris", 4'd7, 5'd16, 3'd0, 2'd1, 4, 29);
    for (int r = 16; r < 20; r++) begin
      readCheck("tetris_row", 5'(r), 10'd0);
    end

    applyStimulus(4'd0, 5'd18, 3'd3, 2'd0, 3'd4);
    place_piece = 1'b1;
    tick;
    place_piece = 1'b0;
    repeat (4) tick;
    checkOutput("abort_busy_before", busy, 1);
    pulseClear;
    checkOutput("abort_busy_after", busy, 0);
    watchNoDone("abort_no_done");
    checkOutput("abort_lines_held", lines_cleared, 4);
    readCheck("abort_row18", 5'd18, 10'd0);
    readCheck("abort_row19", 5'd19, 10'd0);

    for (int i = 0; i < 4; i++) begin
      placeAndWait("rst_build", 4'(2*i), 5'd18, 3'd3, 2'd0, 0, 21);
    end
    applyStimulus(4'd8, 5'd18, 3'd3, 2'd0, 3'd4);
    place_piece = 1'b1;
    tick;
    place_piece = 1'b0;
    tick;
    tick;
    checkOutput("shift_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_done", clear_done, 0);
    checkOutput("rst_mid_lines", lines_cleared, 0);
    tick;
    rst_n = 1'b1;
    watchNoDone("rst_mid_no_done");
    readCheck("rst_mid_row18", 5'd18, 10'd0);
    readCheck("rst_mid_row19", 5'd19, 10'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
